mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum memory wait cycles; a value of 0 disables the timeout.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port opcode, input, 7: IR[6:0]. Port funct3, input, 3: IR[14:12]. Port alu_zero, input, 1: ALU zero flag.
REQ-006 Ports imem_ready and dmem_ready, input, 1 each: memory completion strobes.
REQ-007 Ports imem_read, ir_write, pc_write, output, 1 each: instruction fetch, IR load, and PC load.
REQ-008 Port pc_source, output, 2: 00 = ALU result, 01 = ALUOut register.
REQ-009 Ports alu_src_a (1, output), alu_src_b (2, output), alu_op (2, output): ALU operand and operation selects.
REQ-010 Ports load_reg_a, load_reg_b, load_alu_out, load_mdr, output, 1 each: datapath register enables.
REQ-011 Ports reg_write (1, output) and wb_sel (2, output): register writeback; wb_sel 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-012 Ports dmem_read and dmem_write, output, 1 each: data memory requests.
REQ-013 Ports mem_err (1), trap (1), instret (CNT_W) and state (4), all outputs: error pulse, trap flag, retired count, and current state.

Function
REQ-014 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JAL=10, TRAP=11; all outputs are Moore except the handshake-qualified strobes.
REQ-015 FETCH SHALL hold imem_read=1 until imem_ready=1; in that cycle it asserts ir_write=1 and pc_write=1 with pc_source=00, alu_src_a=0, alu_src_b=01 and alu_op=00 (PC+4), then moves to DECODE.
REQ-016 DECODE SHALL assert load_reg_a, load_reg_b and load_alu_out with alu_src_b=10 (branch target), then dispatch on opcode: 0110011 to EXEC_R, 0010011 to EXEC_I, 0000011 or 0100011 to ADDR, 1100011 to BRANCH, 1101111 to JAL; any other opcode is illegal.
REQ-017 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10 and load_alu_out; EXEC_I SHALL do the same with alu_src_b=10 and alu_op=11. Both then move to ALU_WB.
REQ-018 ALU_WB SHALL assert reg_write=1 with wb_sel=00, then move to FETCH.
REQ-019 ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00 and load_alu_out, then move to MEM_RD for a load or MEM_WR for a store.
REQ-020 MEM_RD SHALL hold dmem_read=1 until dmem_ready=1, assert load_mdr in the ready cycle, then move to MEM_WB; MEM_WB SHALL assert reg_write=1 with wb_sel=01, then move to FETCH.
REQ-021 MEM_WR SHALL hold dmem_write=1 until dmem_ready=1, then move to FETCH.
REQ-022 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01 and pc_source=01; pc_write SHALL be alu_zero for funct3=000, !alu_zero for funct3=001, and 0 otherwise (not taken). BRANCH then moves to FETCH.
REQ-023 JAL SHALL assert pc_write=1 with pc_source=01 and reg_write=1 with wb_sel=10 in one cycle, then move to FETCH; the PC-to-register value is sampled before the PC update.
REQ-024 instret SHALL increment by 1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JAL, and wraps modulo 2^CNT_W.
REQ-025 Memory timeout: a wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle the relevant ready strobe is low.
REQ-026 On reaching MEM_TIMEOUT, the FSM SHALL pulse mem_err for 1 cycle, deassert the request, and go to FETCH (a fetch is retried) without incrementing instret.
REQ-027 A ready strobe in the same cycle the counter reaches MEM_TIMEOUT SHALL win: the transfer completes and mem_err stays 0.
REQ-028 Ready strobes arriving while no request is active SHALL be ignored.

Reset
REQ-029 reset=0 SHALL force state FETCH, instret=0, the wait counter to 0, and mem_err=0 and trap=0 immediately, including mid-transfer; after release the first fetch begins in the next cycle.

Configuration
REQ-030 With CTRL_TRAP_EN defined, an illegal opcode in DECODE SHALL enter TRAP, hold trap=1 with all enables 0, and remain there until reset.
REQ-031 Without CTRL_TRAP_EN, an illegal opcode SHALL return to FETCH as a NOP (PC already advanced, instret increments), and trap SHALL be tied to 0.

Verification
REQ-032 R-type (opcode 0110011), imem_ready=1 every cycle -> state sequence 0,1,2,4,0; instret goes from 0 to 1; reg_write=1 only in ALU_WB.
REQ-033 Load with dmem_ready delayed 3 cycles -> dmem_read held for 4 cycles, load_mdr pulses once, reg_write with wb_sel=01; 6 states plus 3 wait cycles in total.
REQ-034 BEQ with alu_zero=1, then with alu_zero=0 -> pc_write=1 in BRANCH, then pc_write=0 in BRANCH; both retire.
REQ-035 MEM_TIMEOUT=4 with imem_ready stuck at 0 -> mem_err pulses after 4 wait cycles, fetch retries, instret stays 0; a ready strobe on the 4th wait cycle -> no mem_err.
REQ-036 Opcode 1111111 -> with CTRL_TRAP_EN, trap=1 and state=11 until reset; without it, state returns to 0 and instret increments.
REQ-037 Assert reset during a MEM_WR wait -> dmem_write drops immediately; state=0 and instret=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 control FSM with a memory wait timeout and a retired-instruction count.
// Optional: define CTRL_TRAP_EN so that illegal opcodes lock into TRAP until reset.
module mc_control_fsm #(
  parameter int CNT_W       = 64,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_read,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             load_reg_a,
  output logic             load_reg_b,
  output logic             load_alu_out,
  output logic             load_mdr,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             mem_err,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  localparam int WT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int TO_M1 = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WT_W-1:0] TO_LIM = WT_W'(TO_M1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ALU_WB = 4'd4,
    ADDR   = 4'd5,
    MEM_RD = 4'd6,
    MEM_WB = 4'd7,
    MEM_WR = 4'd8,
    BRANCH = 4'd9,
    JAL    = 4'd10,
    TRAP   = 4'd11
  } state_t;

  state_t          st, st_n;
  logic [WT_W-1:0] wait_cnt;
  logic            waiting;
  logic            timeout;
  logic            retire;

  assign waiting = (st == FETCH  && !imem_ready)
                 | (st == MEM_RD && !dmem_ready)
                 | (st == MEM_WR && !dmem_ready);

  // Fires in the wait cycle that brings the counter to the limit; a ready wins.
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TO_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
      mem_err  <= 1'b0;
    end else begin
      st      <= st_n;
      mem_err <= timeout;
      if (retire)
        instret <= instret + CNT_W'(1);
      if (st_n != st || timeout)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + WT_W'(1);
    end
  end

  always_comb begin
    st_n         = st;
    retire       = 1'b0;
    imem_read    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_source    = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    load_reg_a   = 1'b0;
    load_reg_b   = 1'b0;
    load_alu_out = 1'b0;
    load_mdr     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    unique case (st)
      FETCH: begin
        imem_read = 1'b1;
        alu_src_b = 2'b01;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          st_n     = DECODE;
        end
      end
      DECODE: begin
        load_reg_a   = 1'b1;
        load_reg_b   = 1'b1;
        load_alu_out = 1'b1;
        alu_src_b    = 2'b10;
        unique case (opcode)
          OP_R:         st_n = EXEC_R;
          OP_I:         st_n = EXEC_I;
          OP_LD, OP_ST: st_n = ADDR;
          OP_BR:        st_n = BRANCH;
          OP_J:         st_n = JAL;
          default: begin
`ifdef CTRL_TRAP_EN
            st_n = TRAP;
`else
            st_n   = FETCH;
            retire = 1'b1;
`endif
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b10;
        load_alu_out = 1'b1;
        st_n         = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = 2'b11;
        load_alu_out = 1'b1;
        st_n         = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        st_n      = FETCH;
        retire    = 1'b1;
      end
      ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        load_alu_out = 1'b1;
        st_n         = (opcode == OP_LD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        dmem_read = 1'b1;
        if (dmem_ready) begin
          load_mdr = 1'b1;
          st_n     = MEM_WB;
        end else if (timeout) begin
          st_n = FETCH;
        end
      end
      MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
        st_n      = FETCH;
        retire    = 1'b1;
      end
      MEM_WR: begin
        dmem_write = 1'b1;
        if (dmem_ready) begin
          st_n   = FETCH;
          retire = 1'b1;
        end else if (timeout) begin
          st_n = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        unique case (funct3)
          3'b000:  pc_write = alu_zero;
          3'b001:  pc_write = !alu_zero;
          default: pc_write = 1'b0;
        endcase
        st_n   = FETCH;
        retire = 1'b1;
      end
      JAL: begin
        pc_write  = 1'b1;
        pc_source = 2'b01;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        st_n      = FETCH;
        retire    = 1'b1;
      end
      TRAP: begin
`ifdef CTRL_TRAP_EN
        st_n = TRAP;
`else
        st_n = FETCH;
`endif
      end
      default: st_n = FETCH;
    endcase
  end

`ifdef CTRL_TRAP_EN
  assign trap = (st == TRAP);
`else
  assign trap = 1'b0;
`endif

  assign state = st;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (MEM_TIMEOUT=4).
// Expected values are hand-derived per step.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_read;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        load_reg_a;
  logic        load_reg_b;
  logic        load_alu_out;
  logic        load_mdr;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        dmem_read;
  logic        dmem_write;
  logic        mem_err;
  logic        trap;
  logic [63:0] instret;
  logic [3:0]  state;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int ir_exp = 0;
  int rd_cnt;
  int mdr_cnt;
  logic err_seen;

  always #5 clk = ~clk;

  mc_control_fsm #(
    .CNT_W(64),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .funct3(funct3),
    .alu_zero(alu_zero),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_read(imem_read),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_source(pc_source),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .load_reg_a(load_reg_a),
    .load_reg_b(load_reg_b),
    .load_alu_out(load_alu_out),
    .load_mdr(load_mdr),
    .reg_write(reg_write),
    .wb_sel(wb_sel),
    .dmem_read(dmem_read),
    .dmem_write(dmem_write),
    .mem_err(mem_err),
    .trap(trap),
    .instret(instret),
    .state(state)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    opcode = 7'b0;
    funct3 = 3'b0;
    alu_zero = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    // reset state
    nx(); #1;
    chk("rst_state", state, 4'd0);
    chk("rst_instret", instret, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_trap", trap, 0);

    // R-type
    nx();
    reset = 1'b1;
    opcode = 7'b0110011;
    imem_ready = 1'b1;
    #1;
    chk("r_fetch_state", state, 4'd0);
    chk("r_fetch_ir_write", ir_write, 1);
    chk("r_fetch_pc_write", pc_write, 1);
    chk("r_fetch_src_b", alu_src_b, 2'b01);
    chk("r_fetch_rw", reg_write, 0);
    nx(); #1;
    chk("r_dec_state", state, 4'd1);
    chk("r_dec_ld_a", load_reg_a, 1);
    chk("r_dec_ld_b", load_reg_b, 1);
    chk("r_dec_src_b", alu_src_b, 2'b10);
    chk("r_dec_rw", reg_write, 0);
    nx(); #1;
    chk("r_ex_state", state, 4'd2);
    chk("r_ex_src_a", alu_src_a, 1);
    chk("r_ex_op", alu_op, 2'b10);
    chk("r_ex_src_b", alu_src_b, 2'b00);
    chk("r_ex_rw", reg_write, 0);
    nx(); #1;
    chk("r_wb_state", state, 4'd4);
    chk("r_wb_rw", reg_write, 1);
    chk("r_wb_sel", wb_sel, 2'b00);
    nx(); #1;
    chk("r_ret_state", state, 4'd0);
    chk("r_instret", instret, 1);

    // load, dmem_ready after 3 wait cycles
    opcode = 7'b0000011;
    nx(); #1;
    chk("ld_dec_state", state, 4'd1);
    nx(); #1;
    chk("ld_addr_state", state, 4'd5);
    chk("ld_addr_ld_alu", load_alu_out, 1);
    chk("ld_addr_src_b", alu_src_b, 2'b10);
    nx();
    rd_cnt = 0;
    mdr_cnt = 0;
    err_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      if (state == 4'd6 && dmem_read) rd_cnt++;
      if (load_mdr) mdr_cnt++;
      err_seen = err_seen | mem_err;
      nx();
    end
    dmem_ready = 1'b0;
    #1;
    chk("ld_rd_cycles", rd_cnt, 4);
    chk("ld_mdr_pulses", mdr_cnt, 1);
    chk("ld_no_err", err_seen, 0);
    chk("ld_wb_state", state, 4'd7);
    chk("ld_wb_rw", reg_write, 1);
    chk("ld_wb_sel", wb_sel, 2'b01);
    nx(); #1;
    chk("ld_instret", instret, 2);

    // BEQ taken
    opcode = 7'b1100011;
    funct3 = 3'b000;
    alu_zero = 1'b1;
    nx(); nx(); #1;
    chk("beq_t_state", state, 4'd9);
    chk("beq_t_pcw", pc_write, 1);
    chk("beq_t_pcsrc", pc_source, 2'b01);
    chk("beq_t_op", alu_op, 2'b01);
    nx(); #1;
    chk("beq_t_instret", instret, 3);

    // BEQ not taken
    alu_zero = 1'b0;
    nx(); nx(); #1;
    chk("beq_n_state", state, 4'd9);
    chk("beq_n_pcw", pc_write, 0);
    nx(); #1;
    chk("beq_n_instret", instret, 4);

    // BNE taken, then unsupported funct3 never taken
    funct3 = 3'b001;
    nx(); nx(); #1;
    chk("bne_t_pcw", pc_write, 1);
    nx();
    funct3 = 3'b100;
    alu_zero = 1'b1;
    nx(); nx(); #1;
    chk("bxx_pcw", pc_write, 0);
    nx(); #1;
    chk("br_instret", instret, 6);

    // JAL
    opcode = 7'b1101111;
    nx(); nx(); #1;
    chk("jal_state", state, 4'd10);
    chk("jal_pcw", pc_write, 1);
    chk("jal_pcsrc", pc_source, 2'b01);
    chk("jal_rw", reg_write, 1);
    chk("jal_sel", wb_sel, 2'b10);
    nx(); #1;
    chk("jal_instret", instret, 7);

    // I-type, stray dmem_ready must be ignored
    opcode = 7'b0010011;
    dmem_ready = 1'b1;
    nx(); nx(); #1;
    chk("i_ex_state", state, 4'd3);
    chk("i_ex_op", alu_op, 2'b11);
    chk("i_ex_src_b", alu_src_b, 2'b10);
    chk("i_ex_dmem_rd", dmem_read, 0);
    nx(); #1;
    chk("i_wb_state", state, 4'd4);
    nx(); #1;
    dmem_ready = 1'b0;
    chk("i_instret", instret, 8);

    // fetch timeout after 4 wait cycles
    imem_ready = 1'b0;
    opcode = 7'b1111111;
    err_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      err_seen = err_seen | mem_err;
      nx();
    end
    #1;
    chk("to_no_early_err", err_seen, 0);
    chk("to_mem_err", mem_err, 1);
    chk("to_state", state, 4'd0);
    chk("to_imem_read", imem_read, 1);
    chk("to_instret", instret, 8);
    nx(); #1;
    chk("to_err_pulse", mem_err, 0);
    nx(); nx();
    imem_ready = 1'b1;
    #1;
    chk("to_ready_wins_irw", ir_write, 1);
    nx(); #1;
    chk("to_ready_wins_state", state, 4'd1);
    chk("to_ready_wins_err", mem_err, 0);

    // illegal opcode
    nx(); #1;
`ifdef CTRL_TRAP_EN
    chk("ill_state", state, 4'd11);
    chk("ill_trap", trap, 1);
    chk("ill_pcw", pc_write, 0);
    chk("ill_imem_rd", imem_read, 0);
    nx(); nx(); #1;
    chk("ill_hold_state", state, 4'd11);
    chk("ill_hold_trap", trap, 1);
    reset = 1'b0;
    #1;
    chk("ill_rst_trap", trap, 0);
    chk("ill_rst_state", state, 4'd0);
    nx();
    reset = 1'b1;
    ir_exp = 0;
`else
    chk("ill_state", state, 4'd0);
    chk("ill_trap", trap, 0);
    chk("ill_instret", instret, 9);
    ir_exp = 9;
`endif

    // store completing on its 2nd MEM_WR cycle
    opcode = 7'b0100011;
    nx(); nx(); #1;
    chk("st_addr_state", state, 4'd5);
    nx(); #1;
    chk("st_wr_state", state, 4'd8);
    chk("st_wr_dmem_wr", dmem_write, 1);
    nx();
    dmem_ready = 1'b1;
    #1;
    chk("st_wr_hold", dmem_write, 1);
    nx();
    dmem_ready = 1'b0;
    ir_exp = ir_exp + 1;
    #1;
    chk("st_instret", instret, 64'(ir_exp));

    // reset during a store wait
    nx(); nx(); nx(); nx(); #1;
    chk("st2_wr_dmem_wr", dmem_write, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("st2_rst_dmem_wr", dmem_write, 0);
    chk("st2_rst_state", state, 4'd0);
    chk("st2_rst_instret", instret, 0);
    chk("st2_rst_err", mem_err, 0);
    nx();
    reset = 1'b1;
    nx(); #1;
    chk("post_rst_state", state, 4'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
